// File: rtl/cam_init_sequencer.sv
// Walks a camera register-init table in ROM and issues one SCCB write per entry, with ms delays and end marker.
// Optional build macro CAM_INIT_RETRY_EN: retry a timed-out write up to twice before flagging an error.
module cam_init_sequencer #(
    parameter logic [6:0] SLAVE_ADDR     = 7'h21,
    parameter int         ADDR_W         = 8,
    parameter int         GAP_CYCLES     = 16,
    parameter int         TIMEOUT_CYCLES = 4096,
    parameter int         MS_CYCLES      = 25000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              go,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [15:0]       rom_data,
    output logic              sccb_start,
    output logic [6:0]        sccb_slave_addr,
    output logic [7:0]        sccb_reg_addr,
    output logic [7:0]        sccb_data,
    output logic              sccb_rw,
    input  logic              sccb_done,
    output logic              busy,
    output logic              init_done,
    output logic              error
);

    // One shared counter serves the timeout, the gap and the ms delay; it must hold 255 ms worth of cycles.
    localparam int DLY_W = 8 + $clog2(MS_CYCLES);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + GAP_CYCLES) + 1;
    localparam int CNT_W = (DLY_W > TMO_W) ? DLY_W : TMO_W;

    localparam logic [CNT_W-1:0]  TMO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]  GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0]  MS        = CNT_W'(MS_CYCLES);
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    typedef enum logic [3:0] {
        IDLE, FETCH, DECODE, ISSUE, WAIT_DONE, GAP, DELAY, DONE, ERR
    } state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [7:0]        reg_nxt, dat_nxt;
    logic              adv;
`ifdef CAM_INIT_RETRY_EN
    logic [1:0]        retry, retry_nxt;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            rom_addr      <= '0;
            cnt           <= '0;
            sccb_reg_addr <= '0;
            sccb_data     <= '0;
`ifdef CAM_INIT_RETRY_EN
            retry         <= '0;
`endif
        end else begin
            state         <= state_nxt;
            rom_addr      <= addr_nxt;
            cnt           <= cnt_nxt;
            sccb_reg_addr <= reg_nxt;
            sccb_data     <= dat_nxt;
`ifdef CAM_INIT_RETRY_EN
            retry         <= retry_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt = state;
        addr_nxt  = rom_addr;
        cnt_nxt   = cnt;
        reg_nxt   = sccb_reg_addr;
        dat_nxt   = sccb_data;
        adv       = 1'b0;
`ifdef CAM_INIT_RETRY_EN
        retry_nxt = retry;
`endif
        case (state)
            IDLE, DONE, ERR: begin
                if (go) begin
                    state_nxt = FETCH;
                    addr_nxt  = '0;
`ifdef CAM_INIT_RETRY_EN
                    retry_nxt = '0;
`endif
                end
            end
            FETCH: state_nxt = DECODE;
            DECODE: begin
                if (rom_data[15:8] == 8'hFF) begin
                    state_nxt = DONE;
                end else if (rom_data[15:8] == 8'hFE) begin
                    if (rom_data[7:0] == 8'h00) begin
                        adv = 1'b1;
                    end else begin
                        cnt_nxt   = CNT_W'(rom_data[7:0]) * MS;
                        state_nxt = DELAY;
                    end
                end else begin
                    reg_nxt   = rom_data[15:8];
                    dat_nxt   = rom_data[7:0];
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                cnt_nxt   = '0;
                state_nxt = WAIT_DONE;
            end
            WAIT_DONE: begin
                // done in the expiry cycle still counts as success
                if (sccb_done) begin
                    cnt_nxt   = '0;
                    state_nxt = GAP;
`ifdef CAM_INIT_RETRY_EN
                    retry_nxt = '0;
`endif
                end else if (cnt == TMO_LAST) begin
`ifdef CAM_INIT_RETRY_EN
                    if (retry == 2'd2) begin
                        state_nxt = ERR;
                    end else begin
                        retry_nxt = retry + 2'd1;
                        state_nxt = ISSUE;
                    end
`else
                    state_nxt = ERR;
`endif
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            GAP: begin
                if (cnt == GAP_LAST) adv = 1'b1;
                else                 cnt_nxt = cnt + CNT_W'(1);
            end
            DELAY: begin
                if (cnt == CNT_W'(1)) adv = 1'b1;
                else                  cnt_nxt = cnt - CNT_W'(1);
            end
            default: state_nxt = IDLE;
        endcase

        // No wrap: a table without an end marker finishes after its last slot.
        if (adv) begin
            if (rom_addr == LAST_ADDR) begin
                state_nxt = DONE;
            end else begin
                addr_nxt  = rom_addr + ADDR_W'(1);
                state_nxt = FETCH;
            end
        end
    end

    assign sccb_start      = (state == ISSUE);
    assign sccb_slave_addr = SLAVE_ADDR;
    assign sccb_rw         = 1'b0;
    assign busy            = !(state == IDLE || state == DONE || state == ERR);
    assign init_done       = (state == DONE);
    assign error           = (state == ERR);

endmodule
